instruction_loader: RTL and testbench
=====================================

# instruction_loader

Debug-path writer for the instruction memory in the fetch stage. Assembles a byte stream (from the UART receiver in the debug unit) into 32-bit big-endian words and drives the fetch stage's instruction-memory write port (`i_inst_write_enable` / `i_write_addr` / `i_write_data`). Loading stops on a HALT word or when memory is full. While loading, the write-enable pulses hold the fetch PC at 0, so the program starts cleanly afterwards.

## Interface
- `SIZE`, 32: instruction word width; must be a multiple of 8.
- `MAX_INSTRUCTION`, 64: instruction memory depth in words; must match the fetch stage.
- `ADDR_WIDTH`, `$clog2(MAX_INSTRUCTION)`: write address width.
- `HALT_WORD`, 32'hFFFF_FFFF: end-of-program marker.

Ports:
- `i_clk` in 1: single clock, all logic on posedge.
- `i_rst` in 1: reset, synchronous, active-high.
- `i_start` in 1: begin a load; sampled in IDLE or DONE.
- `i_byte_valid` in 1: `i_byte` is valid this cycle; one-cycle strobe per byte, no backpressure.
- `i_byte` in 8: incoming byte, MSB-first per word.
- `o_inst_write_enable` out 1: one-cycle write strobe to instruction memory.
- `o_write_addr` out ADDR_WIDTH: word address for the write.
- `o_write_data` out SIZE: assembled word.
- `o_busy` out 1: high in LOAD.
- `o_done` out 1: high in DONE.
- `o_overflow` out 1: load ended by a full memory, not by HALT; valid while `o_done`.
- `o_word_count` out ADDR_WIDTH+1: words written in the current or last load, HALT included.

## Operation
- States: IDLE, LOAD, DONE.
- IDLE → LOAD on `i_start`. Entry clears the byte index, word counter and `o_overflow`.
- LOAD:
  - Each `i_byte_valid` shifts the byte into the assembly register at bits `[SIZE-1-8*k -: 8]`, where k is the byte index 0..3, then increments k.
  - On the 4th byte, the next cycle raises `o_inst_write_enable` for exactly 1 cycle with `o_write_addr` = word counter and `o_write_data` = the full word. The word counter then increments and k wraps to 0.
  - If the written word equals HALT_WORD → DONE with `o_overflow`=0.
  - Otherwise, if the word counter reaches MAX_INSTRUCTION → DONE with `o_overflow`=1.
- DONE:
  - Bytes are ignored and no writes occur.
  - `i_start` → LOAD, restarting at address 0 with count cleared.
  - HALT check takes priority over the full check, so HALT in the last slot gives `o_overflow`=0.
- `i_start` during LOAD is ignored.
- Bytes arriving in IDLE are ignored.
- A partial word (k≠0) present when reset asserts is discarded.

## Timing
- Reset values:
  - state IDLE
  - `o_inst_write_enable` 0, `o_write_addr` 0, `o_write_data` 0
  - `o_busy` 0, `o_done` 0, `o_overflow` 0, `o_word_count` 0
- Reset asserted mid-LOAD (including on a write cycle) aborts within that edge. No write strobe occurs in the following cycle.
- Latency: 4th-byte valid at edge N → write strobe high during cycle N+1.
- The state changes to DONE at the same edge that ends the final write strobe. `o_done` rises in cycle N+2.
- Back-to-back bytes (`i_byte_valid` every cycle) are supported. The 1st byte of the next word may be accepted in the same cycle as the write strobe.
- All outputs are registered; no combinational path from inputs to outputs.
- `o_word_count` updates in the same cycle the write strobe is high.
- Width rules:
  - The word counter is ADDR_WIDTH+1 bits, so it can represent MAX_INSTRUCTION.
  - `o_write_addr` is the counter's low ADDR_WIDTH bits, always below MAX_INSTRUCTION when a strobe is issued.

## Structure
- Shared package/header holds:
  - HALT_WORD
  - the state encoding (IDLE=2'd0, LOAD=2'd1, DONE=2'd2)
  - the default MAX_INSTRUCTION, shared with the fetch stage
- One natural sub-module, `word_assembler`:
  - Does the byte shift and k counter.
  - Emits a one-cycle `word_valid` with the word.
- `instruction_loader` holds the FSM, the address counter and the output registers.

## Test plan
- **Single program:** reset, `i_start`, then bytes 20 08 00 05 FF FF FF FF every cycle → strobes at addr 0 with 32'h2008_0005 and addr 1 with 32'hFFFF_FFFF; `o_done`=1, `o_overflow`=0, `o_word_count`=2.
- **Gapped bytes:** same stream with 3 idle cycles between bytes → identical writes, strobe 1 cycle after each 4th byte, never 2 cycles wide.
- **Full memory:** MAX_INSTRUCTION=4, send 5 non-HALT words → 4 strobes at addr 0..3, `o_overflow`=1, `o_word_count`=4, 5th word produces no strobe.
- **HALT in last slot:** MAX_INSTRUCTION=4, words 1, 2, 3, HALT → `o_overflow`=0, `o_word_count`=4.
- **Reset mid-word:** send 2 bytes, assert `i_rst` for 1 cycle, then `i_start` and a full program → first write is at addr 0 with correctly aligned bytes, and stale bytes are absent.
- **Ignore and restart:** bytes in IDLE and DONE produce no strobes; `i_start` from DONE reloads from addr 0 with `o_word_count` cleared.

Source files
------------

// File: rtl/instruction_loader_pkg.sv
// Shared constants for the debug-path instruction loader.
// The fetch stage uses the same default memory depth.
package instruction_loader_pkg;

  localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;
  localparam int MAX_INSTRUCTION_DEF = 64;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/instruction_loader_if.sv
// Byte stream in, instruction-memory write port out.
// The slave side belongs to the loader.
interface instruction_loader_if #(
  parameter int SIZE       = 32,
  parameter int ADDR_WIDTH = 6
);

  logic                  i_byte_valid;
  logic [7:0]            i_byte;
  logic                  o_inst_write_enable;
  logic [ADDR_WIDTH-1:0] o_write_addr;
  logic [SIZE-1:0]       o_write_data;

  modport master (
    output i_byte_valid,
    output i_byte,
    input  o_inst_write_enable,
    input  o_write_addr,
    input  o_write_data
  );

  modport slave (
    input  i_byte_valid,
    input  i_byte,
    output o_inst_write_enable,
    output o_write_addr,
    output o_write_data
  );

endinterface

// File: rtl/instruction_loader_word_assembler.sv
// Packs bytes MSB-first into a word.
// Flags the completed word for one cycle.
module word_assembler #(
  parameter int SIZE = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_en,
  input  logic            i_clr,
  input  logic            i_byte_valid,
  input  logic [7:0]      i_byte,
  output logic            o_last,
  output logic            o_word_valid,
  output logic [SIZE-1:0] o_word
);

  localparam int NB = SIZE / 8;
  localparam int KW = (NB > 1) ? $clog2(NB) : 1;

  logic [KW-1:0]   r_k;
  logic [SIZE-1:0] r_shift;
  logic [SIZE-1:0] r_word;
  logic            r_valid;
  logic            w_take;
  logic [SIZE-1:0] w_next;

  assign w_take = i_en && i_byte_valid;
  assign o_last = w_take && (r_k == KW'(NB - 1));

  always_comb begin
    w_next = r_shift;
    w_next[SIZE-1-8*int'(r_k) -: 8] = i_byte;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_k     <= '0;
      r_shift <= '0;
      r_word  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= o_last;
      if (i_clr) begin
        r_k <= '0;
      end else if (w_take) begin
        r_shift <= w_next;
        r_k     <= o_last ? '0 : r_k + 1'b1;
        if (o_last) r_word <= w_next;
      end
    end
  end

  assign o_word_valid = r_valid;
  assign o_word       = r_word;

endmodule

// File: rtl/instruction_loader.sv
// Debug-path writer for the fetch-stage instruction memory.
// Loads words until HALT or until memory is full.
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int SIZE            = 32,
  parameter int MAX_INSTRUCTION = MAX_INSTRUCTION_DEF,
  parameter int ADDR_WIDTH      = $clog2(MAX_INSTRUCTION),
  parameter logic [SIZE-1:0] HALT_WORD = SIZE'(HALT_WORD_DEF)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  instruction_loader_if.slave   io_bus,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_overflow,
  output logic [ADDR_WIDTH:0]   o_word_count
);

  localparam logic [ADDR_WIDTH:0] CNT_MAX =
    (ADDR_WIDTH+1)'(MAX_INSTRUCTION);

  logic [1:0]            r_state;
  logic [ADDR_WIDTH:0]   r_count;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_ov;

  logic                  w_en;
  logic                  w_clr;
  logic                  w_last;
  logic                  w_word_valid;
  logic [SIZE-1:0]       w_word;

  assign w_en  = (r_state == ST_LOAD);
  assign w_clr = i_start &&
                 ((r_state == ST_IDLE) || (r_state == ST_DONE));

  word_assembler #(.SIZE(SIZE)) u_asm (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_en         (w_en),
    .i_clr        (w_clr),
    .i_byte_valid (io_bus.i_byte_valid),
    .i_byte       (io_bus.i_byte),
    .o_last       (w_last),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  // Address is latched with the 4th byte so it is stable
  // for the whole strobe cycle while the count moves on.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_addr  <= '0;
      r_ov    <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            r_state <= ST_LOAD;
            r_count <= '0;
            r_addr  <= '0;
            r_ov    <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (w_last) begin
            r_addr  <= r_count[ADDR_WIDTH-1:0];
            r_count <= r_count + 1'b1;
          end
          if (w_word_valid) begin
            if (w_word == HALT_WORD) begin
              r_state <= ST_DONE;
            end else if (r_count == CNT_MAX) begin
              r_state <= ST_DONE;
              r_ov    <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign io_bus.o_inst_write_enable = w_word_valid;
  assign io_bus.o_write_addr        = r_addr;
  assign io_bus.o_write_data        = w_word;

  assign o_busy       = (r_state == ST_LOAD);
  assign o_done       = (r_state == ST_DONE);
  assign o_overflow   = r_ov;
  assign o_word_count = r_count;

endmodule

// File: tb/tb_instruction_loader.sv
// Scoreboard bench for instruction_loader.
// Small memory depth so the full-memory paths are reachable.
module tb_instruction_loader;
  import instruction_loader_pkg::*;

  localparam int MAXI = 4;
  localparam int AW   = 2;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic        ov;
  logic [AW:0] wcount;

  instruction_loader_if #(.SIZE(32), .ADDR_WIDTH(AW)) bus ();

  instruction_loader #(
    .SIZE            (32),
    .MAX_INSTRUCTION (MAXI)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .io_bus       (bus.slave),
    .o_busy       (busy),
    .o_done       (done),
    .o_overflow   (ov),
    .o_word_count (wcount)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    int            cyc;
  } wr_t;

  wr_t exp_q[$];

  bit          m_act  = 1'b0;
  bit          m_done = 1'b0;
  bit          m_ov   = 1'b0;
  int          m_k    = 0;
  int          m_cnt  = 0;
  logic [31:0] m_word = '0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  logic prev_we = 1'b0;

  always @(negedge clk) begin : mon
    wr_t e;
    if (bus.o_inst_write_enable === 1'b1) begin
      chk("we_width", prev_we, 0);
      chk("wr_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", bus.o_write_addr, e.addr);
        chk("wr_data", bus.o_write_data, e.data);
        chk("wr_cycle", cyc, e.cyc);
      end
    end
    prev_we = bus.o_inst_write_enable;
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.i_byte_valid = 1'b1;
    bus.i_byte       = b;
    if (m_act) begin
      m_word[31-8*m_k -: 8] = b;
      m_k++;
      if (m_k == 4) begin
        exp_q.push_back('{m_cnt[AW-1:0], m_word, cyc + 1});
        m_cnt++;
        m_k = 0;
        if (m_word == HALT_WORD_DEF) begin
          m_act  = 1'b0;
          m_done = 1'b1;
        end else if (m_cnt == MAXI) begin
          m_act  = 1'b0;
          m_done = 1'b1;
          m_ov   = 1'b1;
        end
      end
    end
    @(posedge clk); #1;
    bus.i_byte_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8], gap);
  endtask

  task automatic do_start();
    start  = 1'b1;
    m_act  = 1'b1;
    m_done = 1'b0;
    m_ov   = 1'b0;
    m_k    = 0;
    m_cnt  = 0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    m_act  = 1'b0;
    m_done = 1'b0;
    m_ov   = 1'b0;
    m_k    = 0;
    m_cnt  = 0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic settle_status(input string t);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk({t, ":busy"}, busy, m_act);
    chk({t, ":done"}, done, m_done);
    chk({t, ":ovf"}, ov, m_ov);
    chk({t, ":count"}, wcount, m_cnt);
    chk({t, ":pending"}, exp_q.size(), 0);
  endtask

  initial begin
    bus.i_byte_valid = 1'b0;
    bus.i_byte       = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", bus.o_inst_write_enable, 0);
    chk("rst_addr", bus.o_write_addr, 0);
    chk("rst_data", bus.o_write_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", ov, 0);
    chk("rst_count", wcount, 0);
    rst = 1'b0;

    // back-to-back program; start held during LOAD is ignored
    do_start();
    chk("start_busy", busy, 1);
    send_word(32'h2008_0005, 0);
    start = 1'b1;
    send_word(HALT_WORD_DEF, 0);
    start = 1'b0;
    settle_status("single");

    send_word(32'h1122_3344, 1);
    settle_status("done_ignore");

    do_start();
    chk("restart_count", wcount, 0);
    send_word(32'h2008_0005, 3);
    send_word(HALT_WORD_DEF, 3);
    settle_status("gapped");

    do_start();
    for (int i = 1; i <= 5; i++) send_word(32'hA000_0000 + 32'(i), 0);
    settle_status("full");

    do_start();
    send_word(32'h0000_0001, 0);
    send_word(32'h0000_0002, 1);
    send_word(32'h0000_0003, 0);
    send_word(HALT_WORD_DEF, 0);
    settle_status("halt_last");

    do_start();
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    do_reset();
    settle_status("rst_mid");
    send_word(32'hDEAD_BEEF, 0);
    settle_status("idle_ignore");
    do_start();
    send_word(32'h2008_0005, 0);
    send_word(HALT_WORD_DEF, 0);
    settle_status("after_rst");

    // reset sampled on the same edge as the 4th byte
    do_start();
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_byte(8'h56, 0);
    rst              = 1'b1;
    bus.i_byte_valid = 1'b1;
    bus.i_byte       = 8'h78;
    m_act  = 1'b0;
    m_done = 1'b0;
    m_ov   = 1'b0;
    m_k    = 0;
    m_cnt  = 0;
    @(posedge clk); #1;
    rst              = 1'b0;
    bus.i_byte_valid = 1'b0;
    settle_status("rst_on_last");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
